led_cube_frame_assembler: RTL and testbench

Sits between the UART Avalon reader and `LED_cube_driver`. Takes the received byte stream, locks onto a sync byte, and assembles 64-byte cube frames, one byte per layer/latch pair, into a double-buffered frame store. It swaps the store only on a complete, valid frame, so the driver never displays a torn frame. The driver scans the display bank through a registered read port.

---
 rtl/led_cube_frame_assembler_if.sv | 23 ++
 rtl/led_cube_frame_assembler.sv | 146 ++++++++++++++
 tb/tb_led_cube_frame_assembler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_cube_frame_assembler_if.sv
// Byte-stream input, display-bank read port and frame status shared between
// the UART reader side (master) and the frame assembler (slave).
interface led_cube_frame_assembler_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [2:0] rd_layer;
   logic [2:0] rd_latch;
   logic [7:0] rd_data;
   logic       frame_valid;
   logic       frame_swap;
   logic [7:0] frame_count;
   logic       err_pulse;

   modport master (
      output rx_valid, rx_data, rd_layer, rd_latch,
      input  rd_data, frame_valid, frame_swap, frame_count, err_pulse
   );

   modport slave (
      input  rx_valid, rx_data, rd_layer, rd_latch,
      output rd_data, frame_valid, frame_swap, frame_count, err_pulse
   );
endinterface

// File: rtl/led_cube_frame_assembler.sv
// Sync-locked 64-byte cube frame assembler with a double-buffered frame store.
// Optional XOR checksum byte after the frame: define LED_CUBE_FRAME_CHECKSUM_EN.
module led_cube_frame_assembler #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic                       clock_sink_clk,
   input  logic                       reset_sink_reset,
   led_cube_frame_assembler_if.slave  bus
);

   localparam int unsigned   TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

`ifdef LED_CUBE_FRAME_CHECKSUM_EN
   typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_CHECK, S_SWAP} state_t;
`else
   typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_SWAP} state_t;
`endif

   state_t        r_state;
   logic [5:0]    r_idx;
   logic [TW-1:0] r_tcnt;
   logic          r_disp_bank;
   logic          r_frame_valid;
   logic          r_frame_swap;
   logic [7:0]    r_frame_count;
   logic          r_err_pulse;
   logic [7:0]    r_rd_data;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
   logic [7:0]    r_xor;
`endif

   // Both banks in one array; the MSB of the address is the bank select.
   logic [7:0]    r_mem [0:127];

   logic          w_wr_en;
   logic [6:0]    w_wr_addr;
   logic [6:0]    w_rd_addr;
   logic          w_timeout;

   assign w_wr_en   = (r_state == S_COLLECT) && bus.rx_valid;
   assign w_wr_addr = {~r_disp_bank, r_idx};
   assign w_rd_addr = {r_disp_bank, bus.rd_layer, bus.rd_latch};
   assign w_timeout = (r_tcnt == TMAX);

   always_ff @(posedge clock_sink_clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= bus.rx_data;
      end
   end

   always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
      if (reset_sink_reset) begin
         r_state       <= S_HUNT;
         r_idx         <= '0;
         r_tcnt        <= '0;
         r_disp_bank   <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_swap  <= 1'b0;
         r_frame_count <= '0;
         r_err_pulse   <= 1'b0;
         r_rd_data     <= '0;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
         r_xor         <= '0;
`endif
      end else begin
         r_frame_swap <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_rd_data    <= r_frame_valid ? r_mem[w_rd_addr] : '0;

         case (r_state)
            S_HUNT: begin
               if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                  r_state <= S_COLLECT;
                  r_idx   <= '0;
                  r_tcnt  <= '0;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
                  r_xor   <= '0;
`endif
               end
            end

            S_COLLECT: begin
               if (bus.rx_valid) begin
                  r_idx  <= r_idx + 6'd1;
                  r_tcnt <= '0;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
                  r_xor  <= r_xor ^ bus.rx_data;
                  if (r_idx == 6'd63) begin
                     r_state <= S_CHECK;
                  end
`else
                  // frame_swap is raised on entry so it is high for the whole SWAP cycle.
                  if (r_idx == 6'd63) begin
                     r_state      <= S_SWAP;
                     r_frame_swap <= 1'b1;
                  end
`endif
               end else if (w_timeout) begin
                  r_state     <= S_HUNT;
                  r_err_pulse <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end

`ifdef LED_CUBE_FRAME_CHECKSUM_EN
            S_CHECK: begin
               if (bus.rx_valid) begin
                  r_tcnt <= '0;
                  if (bus.rx_data == r_xor) begin
                     r_state      <= S_SWAP;
                     r_frame_swap <= 1'b1;
                  end else begin
                     r_state     <= S_HUNT;
                     r_err_pulse <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_state     <= S_HUNT;
                  r_err_pulse <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
`endif

            S_SWAP: begin
               r_disp_bank   <= ~r_disp_bank;
               r_frame_count <= r_frame_count + 8'd1;
               r_frame_valid <= 1'b1;
               r_state       <= S_HUNT;
            end

            default: r_state <= S_HUNT;
         endcase
      end
   end

   assign bus.rd_data     = r_rd_data;
   assign bus.frame_valid = r_frame_valid;
   assign bus.frame_swap  = r_frame_swap;
   assign bus.frame_count = r_frame_count;
   assign bus.err_pulse   = r_err_pulse;

endmodule

// File: tb/tb_led_cube_frame_assembler.sv
// Scoreboard bench for led_cube_frame_assembler: a byte-level frame model feeds
// an expected-event queue; a negedge monitor checks pulses, counts and reads.
module tb_led_cube_frame_assembler;

   localparam logic [7:0]  SYNC = 8'hA5;
   localparam int unsigned TMO  = 40;
`ifdef LED_CUBE_FRAME_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   typedef struct packed {
      logic            is_err;
      logic [7:0]      cnt;
      logic [63:0][7:0] frame;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   led_cube_frame_assembler_if bus();

   led_cube_frame_assembler #(
      .SYNC_BYTE(SYNC),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock_sink_clk(clk),
      .reset_sink_reset(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
   endfunction

   function automatic void fail(input string msg);
      n_checks++;
      $display("FAIL %s at %0t", msg, $time);
   endfunction

   // Reference model: frame-level view of the byte stream
   bit          m_hunt = 1'b1;
   logic [7:0]  m_buf[$];
   int unsigned m_gap = 0;
   bit          m_justdone = 1'b0;
   logic [7:0]  m_count = 8'h00;
   ev_t         exp_q[$];
   int          rd_mode = 0;
   logic [5:0]  rd_seq = 6'd0;

   function automatic logic [7:0] buf_xor();
      logic [7:0] x = 8'h00;
      foreach (m_buf[i]) x ^= m_buf[i];
      return x;
   endfunction

   function automatic void model_finish(input bit ok);
      ev_t e;
      e = '0;
      if (ok) begin
         for (int i = 0; i < 64; i++) e.frame[i] = m_buf[i];
         m_count++;
      end
      e.is_err = !ok;
      e.cnt    = m_count;
      exp_q.push_back(e);
      m_hunt = 1'b1;
      m_buf.delete();
      m_justdone = ok;
   endfunction

   task automatic cyc(input logic v, input logic [7:0] d);
      bus.rx_valid = v;
      bus.rx_data  = d;
      case (rd_mode)
         0:       {bus.rd_layer, bus.rd_latch} = 6'($urandom);
         1:       {bus.rd_layer, bus.rd_latch} = 6'd0;
         default: begin
            {bus.rd_layer, bus.rd_latch} = rd_seq;
            rd_seq++;
         end
      endcase
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit dropped;
      dropped    = m_justdone && (m_gap == 0);
      m_justdone = 1'b0;
      if (!dropped) begin
         if (m_hunt) begin
            if (b == SYNC) begin
               m_hunt = 1'b0;
               m_buf.delete();
            end
         end else if (m_buf.size() == 64) begin
            model_finish(b == buf_xor());
         end else begin
            m_buf.push_back(b);
            if (!CS_EN && m_buf.size() == 64) model_finish(1'b1);
         end
      end
      m_gap = 0;
      cyc(1'b1, b);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         m_gap++;
         if (!m_hunt && m_gap == TMO) model_finish(1'b0);
         cyc(1'b0, 8'h00);
      end
   endtask

   task automatic send_frame(input logic [63:0][7:0] fr, input int unsigned maxgap, input bit bad_cs);
      logic [7:0] x;
      x = 8'h00;
      send_byte(SYNC);
      for (int i = 0; i < 64; i++) begin
         idle($urandom_range(0, maxgap));
         send_byte(fr[i]);
         x ^= fr[i];
      end
      if (CS_EN) begin
         idle($urandom_range(0, maxgap));
         send_byte(bad_cs ? ~x : x);
      end
   endtask

   task automatic check_reset_outputs();
      check("reset_rd_data",     bus.rd_data,     8'h00);
      check("reset_frame_valid", bus.frame_valid, 1'b0);
      check("reset_frame_swap",  bus.frame_swap,  1'b0);
      check("reset_frame_count", bus.frame_count, 8'h00);
      check("reset_err_pulse",   bus.err_pulse,   1'b0);
   endtask

   // Monitor: pops an expected event on every pulse, tracks the display model
   initial begin
      bit               have_pend = 1'b0;
      bit               stage     = 1'b0;
      bit               mvalid    = 1'b0;
      logic [7:0]       pend_exp  = 8'h00;
      logic [63:0][7:0] disp      = '0;
      logic [63:0][7:0] staged    = '0;
      logic [7:0]       staged_cnt = 8'h00;
      ev_t              e;
      forever begin
         @(negedge clk);
         if (rst) begin
            have_pend = 1'b0;
            stage     = 1'b0;
            mvalid    = 1'b0;
         end else begin
            if (have_pend) check("rd_data", bus.rd_data, pend_exp);
            if (stage) begin
               disp   = staged;
               mvalid = 1'b1;
               stage  = 1'b0;
               check("frame_count_after_swap", bus.frame_count, staged_cnt);
               check("frame_valid_after_swap", bus.frame_valid, 1'b1);
            end
            pend_exp  = mvalid ? disp[{bus.rd_layer, bus.rd_latch}] : 8'h00;
            have_pend = 1'b1;
            if (bus.frame_swap || bus.err_pulse) begin
               check("swap_err_exclusive", bus.frame_swap & bus.err_pulse, 1'b0);
               if (exp_q.size() == 0) begin
                  fail($sformatf("unexpected_event: got swap=%0b err=%0b, required no pulse",
                                 bus.frame_swap, bus.err_pulse));
               end else begin
                  e = exp_q.pop_front();
                  check("event_is_err", bus.err_pulse, e.is_err);
                  check("frame_count_at_pulse", bus.frame_count, e.is_err ? e.cnt : e.cnt - 8'd1);
                  if (!e.is_err && bus.frame_swap) begin
                     staged     = e.frame;
                     staged_cnt = e.cnt;
                     stage      = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      fail("watchdog: simulation time limit reached, required completion");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0][7:0] fr;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rd_layer = 3'd0;
      bus.rd_latch = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;
      idle(3);

      // Normal frame with leading noise, value = index
      send_byte(8'h00);
      send_byte(8'h13);
      for (int i = 0; i < 64; i++) fr[i] = 8'(i);
      send_frame(fr, 0, 1'b0);
      rd_mode = 2;
      idle(70);
      rd_mode = 0;

      // Timeout after 10 data bytes, then a clean frame
      send_byte(SYNC);
      for (int i = 0; i < 10; i++) send_byte(8'(i + 100));
      idle(TMO + 5);
      for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
      send_frame(fr, 1, 1'b0);
      idle(4);

      // Stale display while reading address 0
      rd_mode = 1;
      send_frame({64{8'h11}}, 0, 1'b0);
      idle(5);
      send_frame({64{8'h22}}, 0, 1'b0);
      idle(5);

      // Embedded sync bytes as data
      rd_mode = 2;
      send_frame({64{SYNC}}, 0, 1'b0);
      idle(70);
      rd_mode = 0;

      // Byte in the SWAP cycle is dropped, even a sync byte
      for (int i = 0; i < 64; i++) fr[i] = 8'(i * 3);
      send_frame(fr, 0, 1'b0);
      send_byte(SYNC);
      for (int i = 0; i < 64; i++) send_byte(8'h5A);
      idle(TMO + 2);
      for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
      send_frame(fr, 2, 1'b0);
      idle(4);

      if (CS_EN) begin
         for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
         send_frame(fr, 1, 1'b1);
         idle(70);
         send_frame(fr, 1, 1'b0);
         idle(70);
      end

      // Reset mid-frame
      send_byte(SYNC);
      for (int i = 0; i < 30; i++) send_byte(8'($urandom));
      rst = 1'b1;
      #1;
      check_reset_outputs();
      m_hunt = 1'b1;
      m_buf.delete();
      m_count = 8'h00;
      m_justdone = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(3);
      for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
      send_frame(fr, 1, 1'b0);
      idle(4);

      // Randomized stream: noise, gaps, occasional timeouts and bad checksums
      for (int f = 0; f < 12; f++) begin
         for (int n = $urandom_range(0, 3); n > 0; n--) send_byte(8'($urandom));
         idle($urandom_range(1, 3));
         for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            send_byte(SYNC);
            for (int k = $urandom_range(0, 40); k > 0; k--) send_byte(8'($urandom));
            idle(TMO);
         end else begin
            send_frame(fr, 2, $urandom_range(0, 5) == 0);
         end
         idle($urandom_range(0, 6));
      end

      idle(20);
      check("expected_events_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
